fft_trigger_ctrl: RTL and testbench
===================================

Name: fft_trigger_ctrl

Overview:
- Sequencer for serial_fft. Decides when a capture starts and drives its single-cycle trigger input.
- Tracks the FFT's active flag and output handshake. Counts completed frames.
- Supports single-shot or continuous capture, with an optional threshold trigger on the real part of the input stream.
- Sits between the control registers and serial_fft. It observes the same sample stream that feeds the FFT.

Parameters:
- N_POINTS, 64: FFT length; output beats per frame.
- DATA_W, 16: width of the signed real sample seen by the threshold comparator.
- PREFILL, 32: valid input samples required after arming before a trigger may be issued.
- HOLDOFF, 8: idle cycles between frames in continuous mode.
- TIMEOUT, 1024: cycle limit for each wait state (only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  pulse; arms the controller when in IDLE.
- stop_i  in  1  pulse; aborts the sequence and returns to IDLE.
- cont_i  in  1  1 = continuous re-arm; 0 = single shot. Sampled at start.
- thr_en_i  in  1  1 = trigger on threshold crossing; 0 = trigger immediately after prefill. Sampled at start.
- thr_i  in  DATA_W  signed threshold.
- smp_r_i  in  DATA_W  signed real part of the input sample.
- smp_valid_i  in  1  input sample valid.
- fft_active_i  in  1  serial_fft active flag.
- fft_valid_i  in  1  serial_fft output valid.
- fft_ready_i  in  1  ready presented to serial_fft output.
- fft_trigger_o  out  1  one-cycle trigger pulse to serial_fft.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when a frame completes.
- frame_cnt_o  out  16  completed frames since reset; wraps at 65535 to 0.
- state_o  out  3  current state encoding for debug.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset: state IDLE. All outputs 0. Internal counters 0. Previous-above-threshold flag 0.
- State encoding: IDLE=0, PREFILL=1, ARMED=2, TRIG=3, WAIT_ACT=4, RUN=5, HOLDOFF=6.
- IDLE: start_i → PREFILL. Latch cont_i and thr_en_i. Clear the prefill counter.
- PREFILL: count smp_valid_i beats. When the count reaches PREFILL (the PREFILL-th beat), go to ARMED on the next cycle.
- ARMED, thr_en=0: go to TRIG on the next cycle.
- ARMED, thr_en=1:
  - Go to TRIG on a rising crossing: a valid sample with smp_r_i >= thr_i, where the previous valid sample was < thr_i.
  - The previous-sample flag updates only on valid beats and is cleared on entry to ARMED.
  - Consequence: the first valid sample in ARMED can never trigger.
- TRIG: assert fft_trigger_o for exactly this one cycle, then go to WAIT_ACT.
- WAIT_ACT: stay until fft_active_i=1, then go to RUN. Clear the beat counter.
- RUN:
  - Count output beats where fft_valid_i && fft_ready_i.
  - On the N_POINTS-th beat: pulse done_o the following cycle, increment frame_cnt_o, and reset the beat counter.
  - Next state: HOLDOFF if cont=1, else IDLE.
  - If fft_active_i falls before N_POINTS beats: set err_o, go to IDLE, no done_o.
- HOLDOFF: wait HOLDOFF cycles, then go to ARMED. There is no re-prefill.
- stop_i:
  - Takes priority in every state.
  - Next state IDLE; fft_trigger_o forced 0 that cycle; no done_o; frame_cnt_o unchanged.
  - In IDLE, stop_i and start_i in the same cycle: stop wins and the controller stays IDLE.
- start_i outside IDLE is ignored.
- err_o is sticky. It is cleared only by rst_i or by a start_i accepted in IDLE.
- Reset mid-operation: return to the reset state next cycle. Any trigger pulse is cut short.
- Latency:
  - start to trigger, thr_en=0: PREFILL valid beats, then ARMED for 1 cycle, then TRIG in the following cycle.
  - With continuous valid input: trigger asserted PREFILL+2 cycles after start_i is sampled.

Optional Feature:
- Macro: FFT_TRIG_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_ACT and in RUN; it resets on every state entry and on every accepted output beat.
  - Reaching TIMEOUT sets err_o and forces IDLE.
- Undefined: no counter. WAIT_ACT and RUN may wait indefinitely, and the TIMEOUT parameter is unused.

Test Plan:
- Single shot, thr_en=0, PREFILL=32, continuous valid, N_POINTS=64: start → fft_trigger_o high exactly 1 cycle, 34 cycles after start. 64 handshakes → done_o pulse once, frame_cnt_o=1, state IDLE, busy_o=0.
- Threshold: thr_i=100, ramp input 0,1,2,… → trigger on the cycle after the sample with value 100 is accepted. Input held constant at 200 from arming → never triggers.
- Continuous mode, 3 frames with ready_i toggling 50%: frame_cnt_o=3. Every pair of consecutive triggers separated by at least HOLDOFF+2 cycles. No prefill between frames.
- stop_i pulsed in WAIT_ACT and again in RUN at beat 30: immediate IDLE, no done_o, frame_cnt_o unchanged, err_o=0.
- fft_active_i dropped at beat 40 → err_o=1 and IDLE. A following start clears err_o.
- With FFT_TRIG_TIMEOUT_EN, TIMEOUT=16, fft_active_i held 0 → err_o set 16 cycles after entering WAIT_ACT. Without the macro, the controller is still in WAIT_ACT after 2000 cycles.

Source files
------------

// File: rtl/fft_trigger_ctrl_if.sv
// fft_trigger_ctrl_if
// Groups the signals shared between the trigger controller and serial_fft:
// the observed input sample stream, the FFT status/handshake signals and
// the single-cycle capture trigger.
//   smp_r       signed real part of the input sample
//   smp_valid   input sample valid
//   fft_active  serial_fft active flag
//   fft_valid   serial_fft output valid
//   fft_ready   ready presented to serial_fft output
//   fft_trigger one-cycle trigger pulse into serial_fft
// master: controller side (drives fft_trigger).
// slave : stream / FFT side (drives everything else).
interface fft_trigger_ctrl_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] smp_r;
  logic                     smp_valid;
  logic                     fft_active;
  logic                     fft_valid;
  logic                     fft_ready;
  logic                     fft_trigger;

  modport master (
    input  smp_r, smp_valid, fft_active, fft_valid, fft_ready,
    output fft_trigger
  );

  modport slave (
    output smp_r, smp_valid, fft_active, fft_valid, fft_ready,
    input  fft_trigger
  );
endinterface

// File: rtl/fft_trigger_ctrl.sv
// fft_trigger_ctrl
// Capture sequencer for serial_fft: waits for a prefill of valid samples,
// optionally for a rising threshold crossing, fires a one-cycle trigger,
// then tracks the FFT active flag and output handshake and counts frames.
// Single-shot or continuous (with holdoff) operation.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i, stop_i     arm (from IDLE) / abort pulses; stop has priority
//   cont_i, thr_en_i    continuous mode / threshold trigger, latched at start
//   thr_i               signed threshold for the crossing detector
//   fft_if (master)     sample stream, FFT handshake, trigger output
//   busy_o              not IDLE
//   done_o              one-cycle pulse after the last beat of a frame
//   frame_cnt_o         completed frames, wraps
//   state_o             state encoding for debug
//   err_o               sticky error (active lost mid-frame, or timeout)
//
// Optional: define FFT_TRIG_TIMEOUT_EN to bound WAIT_ACT and RUN to TIMEOUT
// cycles (restarted on each state entry and accepted output beat).
//
// state    | meaning
// IDLE     | waiting for start_i
// PREFILL  | counting PREFILL valid input samples
// ARMED    | waiting for trigger condition
// TRIG     | fft_trigger high for this cycle
// WAIT_ACT | waiting for serial_fft to go active
// RUN      | counting N_POINTS output handshakes
// HOLDOFF  | idle gap before re-arming in continuous mode
module fft_trigger_ctrl #(
  parameter int N_POINTS = 64,
  parameter int DATA_W   = 16,
  parameter int PREFILL  = 32,
  parameter int HOLDOFF  = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     cont_i,
  input  logic                     thr_en_i,
  input  logic signed [DATA_W-1:0] thr_i,
  fft_trigger_ctrl_if.master       fft_if,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [15:0]              frame_cnt_o,
  output logic [2:0]               state_o,
  output logic                     err_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREFILL  = 3'd1,
    S_ARMED    = 3'd2,
    S_TRIG     = 3'd3,
    S_WAIT_ACT = 3'd4,
    S_RUN      = 3'd5,
    S_HOLDOFF  = 3'd6
  } state_t;

  localparam int CNT_MAX_A = (PREFILL > N_POINTS) ? PREFILL : N_POINTS;
  localparam int CNT_MAX   = (CNT_MAX_A > HOLDOFF) ? CNT_MAX_A : HOLDOFF;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cont_q, thr_en_q;
  logic             below_q;
  logic             done_q;
  logic [15:0]      frame_cnt_q;
  logic             err_q;

  logic beat, start_ok, crossing, cnt_last, to_hit;
  logic frame_done, err_set;

  assign beat     = fft_if.fft_valid && fft_if.fft_ready;
  assign start_ok = (state_q == S_IDLE) && start_i && !stop_i;
  // below_q means "a previous valid sample in ARMED exists and was below
  // the threshold", so the first sample after entering ARMED cannot fire.
  assign crossing = fft_if.smp_valid && below_q && (fft_if.smp_r >= thr_i);
  // Shared down-counter: loaded on state entry, terminal count at 1.
  assign cnt_last = (cnt_q == CNT_W'(1));

`ifdef FFT_TRIG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign to_hit = (to_cnt_q == TO_W'(1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_d != state_q) || ((state_q == S_RUN) && beat)) begin
      to_cnt_d = TO_W'(TIMEOUT);
    end else if ((state_q == S_WAIT_ACT) || (state_q == S_RUN)) begin
      to_cnt_d = to_cnt_q - TO_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign to_hit = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    err_set    = 1'b0;
    if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (start_i) state_d = S_PREFILL;
        S_PREFILL:  if (fft_if.smp_valid && cnt_last) state_d = S_ARMED;
        S_ARMED:    if (!thr_en_q || crossing) state_d = S_TRIG;
        S_TRIG:     state_d = S_WAIT_ACT;
        S_WAIT_ACT: begin
          if (fft_if.fft_active) begin
            state_d = S_RUN;
          end else if (to_hit) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          // The final beat completes the frame even if active drops with it.
          if (beat && cnt_last) begin
            frame_done = 1'b1;
            state_d    = cont_q ? S_HOLDOFF : S_IDLE;
          end else if (!fft_if.fft_active || (to_hit && !beat)) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_HOLDOFF:  if (cnt_last) state_d = S_ARMED;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        S_PREFILL: cnt_d = CNT_W'(PREFILL);
        S_RUN:     cnt_d = CNT_W'(N_POINTS);
        S_HOLDOFF: cnt_d = CNT_W'(HOLDOFF);
        default:   cnt_d = '0;
      endcase
    end else begin
      case (state_q)
        S_PREFILL: if (fft_if.smp_valid) cnt_d = cnt_q - CNT_W'(1);
        S_RUN:     if (beat) cnt_d = cnt_q - CNT_W'(1);
        S_HOLDOFF: cnt_d = cnt_q - CNT_W'(1);
        default:   cnt_d = cnt_q;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cont_q      <= 1'b0;
      thr_en_q    <= 1'b0;
      below_q     <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= frame_done;
      if (start_ok) begin
        cont_q   <= cont_i;
        thr_en_q <= thr_en_i;
      end
      if (state_q != S_ARMED) begin
        below_q <= 1'b0;
      end else if (fft_if.smp_valid) begin
        below_q <= (fft_if.smp_r < thr_i);
      end
      if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (start_ok) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Outputs; the trigger is gated so stop or reset in TRIG suppress it.
  always_comb begin
    fft_if.fft_trigger = (state_q == S_TRIG) && !stop_i && !rst_i;
    busy_o             = (state_q != S_IDLE);
    state_o            = state_q;
  end

  assign done_o      = done_q;
  assign frame_cnt_o = frame_cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fft_trigger_ctrl.sv
module tb_fft_trigger_ctrl;
  localparam int N_POINTS = 64;
  localparam int DATA_W   = 16;
  localparam int PREFILL  = 32;
  localparam int HOLDOFF  = 8;
  localparam int TIMEOUT  = 16;
  localparam int SRC_LEN  = 512;
  localparam int LIM      = 480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, cont, thr_en;
  logic signed [DATA_W-1:0] thr;
  logic busy, done, err;
  logic [15:0] frame_cnt;
  logic [2:0] state;

  fft_trigger_ctrl_if #(.DATA_W(DATA_W)) fif();

  fft_trigger_ctrl #(
    .N_POINTS(N_POINTS), .DATA_W(DATA_W), .PREFILL(PREFILL),
    .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .cont_i(cont), .thr_en_i(thr_en), .thr_i(thr), .fft_if(fif),
    .busy_o(busy), .done_o(done), .frame_cnt_o(frame_cnt),
    .state_o(state), .err_o(err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int trig_cyc[$];
  int done_cyc[$];
  bit v_arr[SRC_LEN];
  int s_arr[SRC_LEN];
  bit src_on = 1'b0;
  int src_base = 0;
  int exp_frames = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic drive_src();
    int idx = cyc - src_base;
    if (src_on && idx >= 0 && idx < SRC_LEN) begin
      fif.smp_valid = v_arr[idx];
      fif.smp_r     = DATA_W'(s_arr[idx]);
    end else begin
      fif.smp_valid = 1'b0;
    end
  endtask

  // One clock: observe at the falling edge, advance past the rising edge.
  task automatic step();
    @(negedge clk);
    if (fif.fft_trigger) trig_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
    drive_src();
  endtask

  // mode 0: always valid, random samples; 1: random valid, random samples;
  // 2: random valid, ramp over accepted samples; 3: random valid, constant 200
  task automatic fill_src(input int mode);
    int val = 0;
    for (int i = 0; i < SRC_LEN; i++) begin
      v_arr[i] = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 70);
      case (mode)
        2:       s_arr[i] = val;
        3:       s_arr[i] = 200;
        default: s_arr[i] = int'($urandom_range(0, 400)) - 200;
      endcase
      if (v_arr[i]) val++;
    end
  endtask

  // Trigger cycle relative to the start cycle (index 0), or -1 if none by LIM.
  function automatic int exp_trigger(input bit ten, input int th);
    int n = 0;
    int arm = -1;
    bit have_below = 1'b0;
    for (int i = 1; i < SRC_LEN && arm < 0; i++) begin
      if (v_arr[i]) n++;
      if (n == PREFILL) arm = i + 1;
    end
    if (arm < 0) return -1;
    if (!ten) return (arm + 1 <= LIM) ? arm + 1 : -1;
    for (int i = arm; i < SRC_LEN; i++) begin
      if (v_arr[i]) begin
        if (s_arr[i] >= th && have_below) return (i + 1 <= LIM) ? i + 1 : -1;
        have_below = (s_arr[i] < th);
      end
    end
    return -1;
  endfunction

  task automatic arm_and_wait(input bit ten, input int th, input string tag);
    int e = exp_trigger(ten, th);
    trig_cyc.delete();
    done_cyc.delete();
    thr = DATA_W'(th);
    thr_en = ten;
    start = 1'b1;
    src_base = cyc;
    src_on = 1'b1;
    drive_src();
    step();
    while (trig_cyc.size() == 0 && cyc - src_base <= LIM) begin
      start = (cyc - src_base == 4);  // ignored: already in PREFILL
      step();
    end
    start = 1'b0;
    src_on = 1'b0;
    fif.smp_valid = 1'b0;
    check({tag, "_ntrig"}, trig_cyc.size(), (e < 0) ? 0 : 1);
    if (e >= 0) check({tag, "_tcyc"}, qget(trig_cyc, 0) - src_base, e);
  endtask

  // action 0: finish the frame; 1: stop after target beats; 2: drop active
  task automatic run_fft(input int target, input int action, input int rdy_pct,
                         output int last);
    int beats = 0;
    int guard = 0;
    last = -1;
    repeat ($urandom_range(1, 3)) step();
    fif.fft_active = 1'b1;
    fif.fft_valid = 1'b0;
    fif.fft_ready = 1'b0;
    step();
    while (beats < target && guard < 4000) begin
      fif.fft_valid = ($urandom_range(0, 99) < 80);
      fif.fft_ready = ($urandom_range(0, 99) < rdy_pct);
      if (fif.fft_valid && fif.fft_ready) begin
        beats++;
        last = cyc;
      end
      step();
      guard++;
    end
    if (beats < target) check("fft_beat_bound", beats, target);
    fif.fft_valid = 1'b0;
    fif.fft_ready = 1'b0;
    case (action)
      1: begin stop = 1'b1; step(); stop = 1'b0; fif.fft_active = 1'b0; end
      2: begin fif.fft_active = 1'b0; step(); end
      default: fif.fft_active = 1'b0;
    endcase
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check({tag, "_state"}, state, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_frames"}, frame_cnt, exp_frames);
  endtask

  task automatic abort_at_trig(input bit use_rst, input string tag);
    fill_src(0);
    trig_cyc.delete();
    thr_en = 1'b0;
    cont = 1'b0;
    start = 1'b1;
    src_base = cyc;
    src_on = 1'b1;
    drive_src();
    step();
    start = 1'b0;
    repeat (PREFILL + 1) step();
    check({tag, "_at_trig"}, state, 3);
    if (use_rst) rst = 1'b1; else stop = 1'b1;
    step();
    rst = 1'b0;
    stop = 1'b0;
    src_on = 1'b0;
    check({tag, "_ntrig"}, trig_cyc.size(), 0);
    check({tag, "_state"}, state, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int last;
    int lasts[3];
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; thr_en = 1'b0; thr = '0;
    fif.smp_r = '0; fif.smp_valid = 1'b0; fif.fft_active = 1'b0;
    fif.fft_valid = 1'b0; fif.fft_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frames", frame_cnt, 0);
    check("rst_err", err, 0);
    check("rst_trig", fif.fft_trigger, 0);

    // Single shot, continuous then random valid prefill
    for (int k = 0; k < 2; k++) begin
      fill_src(k);
      cont = 1'b0;
      arm_and_wait(1'b0, 0, "single");
      if (k == 0) check("single_lat", qget(trig_cyc, 0) - src_base, PREFILL + 2);
      run_fft(N_POINTS, 0, 70, last);
      repeat (3) step();
      exp_frames++;
      check("single_ntrig_end", trig_cyc.size(), 1);
      check("single_ndone", done_cyc.size(), 1);
      check("single_done_cyc", qget(done_cyc, 0), last + 1);
      check("single_frames", frame_cnt, exp_frames);
      check("single_state", state, 0);
      check("single_busy", busy, 0);
    end

    // Threshold: ramp, random, constant above threshold
    fill_src(2);
    arm_and_wait(1'b1, 100, "ramp");
    check("ramp_wait_state", state, 4);
    do_stop("stop_wait");
    check("stop_wait_ndone", done_cyc.size(), 0);
    for (int k = 0; k < 3; k++) begin
      fill_src(1);
      arm_and_wait(1'b1, int'($urandom_range(0, 100)) - 50, "thr_rand");
      do_stop("thr_rand_stop");
    end
    fill_src(3);
    arm_and_wait(1'b1, 100, "const200");
    check("const200_state", state, 2);
    do_stop("const200_stop");

    // Continuous, 3 frames, ready 50%
    fill_src(0);
    cont = 1'b1;
    arm_and_wait(1'b0, 0, "cont");
    for (int f = 0; f < 3; f++) begin
      if (f > 0) begin
        for (int g = 0; g < 100 && trig_cyc.size() < f + 1; g++) step();
        check("cont_next_trig", trig_cyc.size(), f + 1);
      end
      run_fft(N_POINTS, 0, 50, lasts[f]);
    end
    repeat (4) step();
    exp_frames += 3;
    check("cont_ndone", done_cyc.size(), 3);
    check("cont_ntrig", trig_cyc.size(), 3);
    for (int f = 0; f < 3; f++) check("cont_done_cyc", qget(done_cyc, f), lasts[f] + 1);
    for (int f = 1; f < 3; f++) begin
      check("cont_retrig_cyc", qget(trig_cyc, f) - lasts[f-1], HOLDOFF + 2);
      check("cont_gap", (qget(trig_cyc, f) - qget(trig_cyc, f-1)) >= HOLDOFF + 2, 1);
    end
    check("cont_frames", frame_cnt, exp_frames);
    do_stop("cont_stop");
    cont = 1'b0;

    // Stop in RUN at beat 30
    fill_src(0);
    arm_and_wait(1'b0, 0, "run_stop");
    run_fft(30, 1, 70, last);
    check("run_stop_state", state, 0);
    check("run_stop_err", err, 0);
    repeat (2) step();
    check("run_stop_ndone", done_cyc.size(), 0);
    check("run_stop_frames", frame_cnt, exp_frames);

    // Active dropped at beat 40, then start clears the error
    fill_src(0);
    arm_and_wait(1'b0, 0, "drop");
    run_fft(40, 2, 70, last);
    check("drop_err", err, 1);
    check("drop_state", state, 0);
    check("drop_ndone", done_cyc.size(), 0);
    check("drop_frames", frame_cnt, exp_frames);
    start = 1'b1;
    step();
    start = 1'b0;
    check("drop_clr_err", err, 0);
    check("drop_clr_state", state, 1);
    do_stop("drop_stop");

    // Stop and start together in IDLE
    stop = 1'b1;
    start = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b0;
    step();
    check("ss_state", state, 0);
    check("ss_busy", busy, 0);

    // WAIT_ACT with fft_active held low
    fill_src(0);
    arm_and_wait(1'b0, 0, "to");
`ifdef FFT_TRIG_TIMEOUT_EN
    repeat (TIMEOUT - 1) step();
    check("to_pre_err", err, 0);
    check("to_pre_state", state, 4);
    step();
    check("to_err", err, 1);
    check("to_state", state, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("to_err_clr", err, 0);
    do_stop("to_stop");
`else
    repeat (2000) step();
    check("noto_state", state, 4);
    check("noto_err", err, 0);
    do_stop("noto_stop");
`endif

    // Stop and reset landing on the trigger cycle
    abort_at_trig(1'b0, "stop_trig");
    check("stop_trig_frames", frame_cnt, exp_frames);
    abort_at_trig(1'b1, "rst_trig");
    exp_frames = 0;
    check("rst_trig_frames", frame_cnt, exp_frames);
    check("rst_trig_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
